// File: rtl/sample_ready_flag_gen.sv
// Sample-ready flag generator: Avalon-MM slave that decimates the ADC
// sample-valid stream. It raises a sticky new_sample flag for a Nios II input
// PIO and can raise an optional interrupt. It also tracks overruns, which are
// new events that arrive while the flag is still pending.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   address[1:0]        word address: 0 STATUS, 1 CONTROL, 2 DECIM, 3 OVR_COUNT
//   chipselect, write_n Avalon write strobe (write = chipselect & ~write_n)
//   writedata[31:0]     Avalon write data
//   readdata[31:0]      registered read data, 1-cycle latency, updated every clk
//   adc_valid           one-cycle pulse per converted ADC sample
//   new_sample          sticky sample-ready flag
//   irq                 new_sample & irq_en
module sample_ready_flag_gen #(
  parameter int unsigned DECIM_W = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        adc_valid,
  output logic        new_sample,
  output logic        irq
);

  localparam logic [1:0] AddrStatus  = 2'd0;
  localparam logic [1:0] AddrControl = 2'd1;
  localparam logic [1:0] AddrDecim   = 2'd2;
  localparam logic [1:0] AddrOvrCnt  = 2'd3;

  logic               flag_q, flag_d;
  logic               overrun_q, overrun_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic [DECIM_W-1:0] decim_q, decim_d;
  logic [DECIM_W-1:0] counter_q, counter_d;
  logic [CNT_W-1:0]   ovr_count_q, ovr_count_d;
  logic [31:0]        readdata_q, readdata_d;

  logic write_en;
  logic wr_status, wr_control, wr_decim, wr_ovr_count;
  logic ack_flag, ack_overrun;
  logic enable, irq_en;
  logic sample_event, overrun_event;

  assign write_en     = chipselect & ~write_n;
  assign wr_status    = write_en && (address == AddrStatus);
  assign wr_control   = write_en && (address == AddrControl);
  assign wr_decim     = write_en && (address == AddrDecim);
  assign wr_ovr_count = write_en && (address == AddrOvrCnt);

  assign ack_flag    = wr_status & writedata[0];
  assign ack_overrun = wr_status & writedata[1];

  assign enable = ctrl_q[0];
  assign irq_en = ctrl_q[1];

  // A DECIM write restarts the decimation, so it suppresses any event that cycle.
  assign sample_event = enable && adc_valid && !wr_decim && (counter_q == decim_q);

  // An ack that coincides with an event consumes the old sample, so that event
  // is not an overrun.
  assign overrun_event = sample_event && flag_q && !ack_flag;

  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_control) ctrl_d = writedata[1:0];

    decim_d = decim_q;
    if (wr_decim) decim_d = writedata[DECIM_W-1:0];

    counter_d = counter_q;
    if (!enable || wr_decim) begin
      counter_d = '0;
    end else if (adc_valid) begin
      counter_d = (counter_q == decim_q) ? '0 : counter_q + 1'b1;
    end

    flag_d = flag_q;
    if (ack_flag) flag_d = 1'b0;
    if (sample_event) flag_d = 1'b1;

    overrun_d = overrun_q;
    if (ack_overrun) overrun_d = 1'b0;
    if (overrun_event) overrun_d = 1'b1;

    ovr_count_d = ovr_count_q;
    if (overrun_event && (ovr_count_q != {CNT_W{1'b1}})) ovr_count_d = ovr_count_q + 1'b1;
    if (wr_ovr_count) ovr_count_d = '0;

    readdata_d = '0;
    unique case (address)
      AddrStatus:  readdata_d[1:0] = {overrun_q, flag_q};
      AddrControl: readdata_d[1:0] = ctrl_q;
      AddrDecim:   readdata_d[DECIM_W-1:0] = decim_q;
      AddrOvrCnt:  readdata_d[CNT_W-1:0] = ovr_count_q;
      default:     readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_q      <= 1'b0;
      overrun_q   <= 1'b0;
      ctrl_q      <= '0;
      decim_q     <= '0;
      counter_q   <= '0;
      ovr_count_q <= '0;
      readdata_q  <= '0;
    end else begin
      flag_q      <= flag_d;
      overrun_q   <= overrun_d;
      ctrl_q      <= ctrl_d;
      decim_q     <= decim_d;
      counter_q   <= counter_d;
      ovr_count_q <= ovr_count_d;
      readdata_q  <= readdata_d;
    end
  end

  assign readdata   = readdata_q;
  assign new_sample = flag_q;
  assign irq        = flag_q & irq_en;

endmodule

// File: tb/tb_sample_ready_flag_gen.sv
// Directed testbench for sample_ready_flag_gen. The counter width is 4 so
// that overrun-count saturation can be reached quickly.
module tb_sample_ready_flag_gen;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        adc_valid;
  logic        new_sample;
  logic        irq;

  int unsigned n_checks;
  int unsigned n_fails;
  logic [31:0] rdata;

  sample_ready_flag_gen #(
    .DECIM_W(8),
    .CNT_W  (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .adc_valid (adc_valid),
    .new_sample(new_sample),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data,
                           input logic with_valid);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    adc_valid  = with_valid;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    adc_valid  = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    address = addr;
    tick();
    data = readdata;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      adc_valid = 1'b1;
      tick();
    end
    adc_valid = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    adc_valid  = 1'b0;

    // Reset state
    #3;
    check_eq("rst_readdata", readdata, 32'h0);
    check_eq("rst_new_sample", {31'b0, new_sample}, 32'h0);
    check_eq("rst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    for (int a = 0; a < 4; a++) begin
      bus_read(a[1:0], rdata);
      check_eq($sformatf("rst_read_addr%0d", a), rdata, 32'h0);
    end

    // Basic flag with DECIM=3: the flag appears only after the 4th pulse edge
    bus_write(2'd1, 32'h1, 1'b0);
    bus_write(2'd2, 32'h3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      adc_valid = 1'b1;
      tick();
      if (i < 3) check_eq($sformatf("basic_no_flag_%0d", i), {31'b0, new_sample}, 32'h0);
    end
    adc_valid = 1'b0;
    check_eq("basic_flag_set", {31'b0, new_sample}, 32'h1);
    bus_read(2'd0, rdata);
    check_eq("basic_status", rdata, 32'h1);
    bus_read(2'd2, rdata);
    check_eq("decim_readback", rdata, 32'h3);
    bus_write(2'd0, 32'h1, 1'b0);
    check_eq("basic_ack_clears", {31'b0, new_sample}, 32'h0);

    // An ack and an event in the same cycle: the event wins, and no overrun is counted
    bus_write(2'd2, 32'h0, 1'b0);
    pulses(1);
    check_eq("sim_flag_pre", {31'b0, new_sample}, 32'h1);
    bus_write(2'd0, 32'h1, 1'b1);
    check_eq("sim_ack_flag_kept", {31'b0, new_sample}, 32'h1);
    bus_read(2'd0, rdata);
    check_eq("sim_ack_status", rdata, 32'h1);
    bus_read(2'd3, rdata);
    check_eq("sim_ack_ovr_count", rdata, 32'h0);

    // Overrun and saturation of the 4-bit counter
    pulses(20);
    bus_read(2'd0, rdata);
    check_eq("ovr_status", rdata, 32'h3);
    bus_read(2'd3, rdata);
    check_eq("ovr_saturated", rdata, 32'hF);
    bus_write(2'd3, 32'h0, 1'b0);
    bus_read(2'd3, rdata);
    check_eq("ovr_cleared", rdata, 32'h0);
    pulses(2);
    bus_read(2'd3, rdata);
    check_eq("ovr_count_2", rdata, 32'h2);
    // A clear beats an increment in the same cycle
    bus_write(2'd3, 32'h0, 1'b1);
    bus_read(2'd3, rdata);
    check_eq("ovr_clear_wins", rdata, 32'h0);
    // An overrun set beats a bit1 clear in the same cycle
    bus_write(2'd0, 32'h2, 1'b1);
    bus_read(2'd0, rdata);
    check_eq("ovr_set_wins", rdata, 32'h3);
    bus_read(2'd3, rdata);
    check_eq("ovr_count_1", rdata, 32'h1);
    bus_write(2'd0, 32'h3, 1'b0);
    bus_read(2'd0, rdata);
    check_eq("status_all_clear", rdata, 32'h0);

    // A DECIM write with a coincident pulse zeroes the counter and fires no event
    bus_write(2'd2, 32'h5, 1'b0);
    pulses(3);
    bus_write(2'd2, 32'h5, 1'b1);
    check_eq("decim_wr_no_event", {31'b0, new_sample}, 32'h0);
    pulses(5);
    check_eq("decim_5_pulses", {31'b0, new_sample}, 32'h0);
    pulses(1);
    check_eq("decim_6th_pulse", {31'b0, new_sample}, 32'h1);

    // While disabled, pulses are ignored and the flag is kept
    bus_write(2'd1, 32'h0, 1'b0);
    pulses(10);
    check_eq("disabled_flag_kept", {31'b0, new_sample}, 32'h1);
    bus_read(2'd0, rdata);
    check_eq("disabled_no_overrun", rdata, 32'h1);

    // IRQ gating and CONTROL readback
    bus_write(2'd1, 32'h3, 1'b0);
    check_eq("irq_on", {31'b0, irq}, 32'h1);
    bus_write(2'd1, 32'h1, 1'b0);
    check_eq("irq_off", {31'b0, irq}, 32'h0);
    check_eq("irq_off_flag", {31'b0, new_sample}, 32'h1);
    bus_read(2'd1, rdata);
    check_eq("control_readback", rdata, 32'h1);

    // Reset asserted mid-operation clears outputs with no clock edge
    adc_valid = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("midrst_readdata", readdata, 32'h0);
    check_eq("midrst_new_sample", {31'b0, new_sample}, 32'h0);
    check_eq("midrst_irq", {31'b0, irq}, 32'h0);
    adc_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    for (int a = 0; a < 4; a++) begin
      bus_read(a[1:0], rdata);
      check_eq($sformatf("midrst_read_addr%0d", a), rdata, 32'h0);
    end
    // Enable is cleared after reset, so pulses must not raise the flag
    pulses(3);
    check_eq("midrst_disabled", {31'b0, new_sample}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/sample_ready_flag_gen.md
Name: sample_ready_flag_gen

Overview:
Avalon-MM slave that produces the "new sample available" flag consumed by the Nios II single-bit input PIO.
- Decimates the ADC sample-valid stream.
- Raises a sticky new_sample flag and optional interrupt.
- Holds the flag until software acknowledges it by writing to the slave.
- Flags and counts overruns (new event while flag still pending).

Parameters:
DECIM_W, 8, width of decimation register/counter (flag every DECIM+1 adc_valid pulses)
CNT_W, 16, width of saturating overrun counter

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
address  in  2  Avalon word address
chipselect  in  1  Avalon slave select
write_n  in  1  Avalon write strobe, active-low
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data, registered
adc_valid  in  1  one-cycle pulse per converted ADC sample
new_sample  out  1  sticky sample-ready flag (drives PIO in_port)
irq  out  1  interrupt = new_sample & irq_en

Behaviour:
- Reset is clk/reset_n: asynchronous, active-low. On reset, all state clears: flag, overrun, ctrl, decim, counter, ovr_count; readdata=0, new_sample=0, irq=0.
- Write = chipselect & ~write_n; takes effect on the next clk edge.
- Register map:
  - addr0 STATUS: read bit0=flag, bit1=overrun. Write 1 to bit0 clears flag; write 1 to bit1 clears overrun. Writing 0 has no effect.
  - addr1 CONTROL: bit0=enable, bit1=irq_en; read back as written.
  - addr2 DECIM: bits[DECIM_W-1:0]. Any write also zeroes the decimation counter.
  - addr3 OVR_COUNT: read-only value, zero-extended. Any write clears it to 0.
- Unused readdata bits are 0.
- readdata is registered every clk regardless of read strobe: readdata <= mux(address). Read latency is 1 cycle.
- Decimation:
  - When enable=1 and adc_valid=1: if counter==DECIM, then counter<=0 and event fires; else counter<=counter+1.
  - DECIM=0 means every adc_valid is an event.
  - When enable=0: counter held at 0, no events, existing flag retained.
- Event handling:
  - If flag=0: flag<=1.
  - If flag=1: overrun<=1 and ovr_count<=ovr_count+1, saturating at all-ones (no wrap).
- Simultaneous event and STATUS bit0 clear in the same cycle: the event wins. flag stays 1, and no overrun is counted (the old sample is considered consumed).
- Simultaneous event-overrun and STATUS bit1 clear: the overrun set wins, overrun=1.
- Simultaneous overrun increment and OVR_COUNT write: the clear wins, result is 0.
- Simultaneous DECIM write and adc_valid: the counter is zeroed and no event fires that cycle.
- new_sample = flag register directly, no extra latency. The flag is visible the cycle after the event edge.
- irq is combinational from registers: flag & irq_en.
- Reset asserted mid-operation clears everything immediately (async). Decimation restarts from 0 after reset release, enable=0.

Test Plan:
- Reset: assert reset_n=0 during activity -> readdata=0, new_sample=0, irq=0 immediately; after release, reads of addr0..3 return 0.
- Basic flag: CONTROL=1, DECIM=3, 4 adc_valid pulses -> new_sample rises 1 clk after 4th pulse edge; STATUS read =0x1; write STATUS=0x1 -> new_sample=0 next clk.
- Overrun/saturation: CNT_W=4, DECIM=0, no ack, 20 adc_valid pulses -> STATUS=0x3, OVR_COUNT=15 (saturated); write addr3 -> OVR_COUNT=0.
- Simultaneous ack and event: flag=1, STATUS bit0 write same cycle as event -> flag remains 1, overrun stays 0, OVR_COUNT unchanged.
- Enable/DECIM edge: DECIM=5, 3 pulses, write DECIM=5 with coincident adc_valid -> no event; 6 further pulses needed for the flag. enable=0 -> pulses ignored, flag kept.
- IRQ/readback: CONTROL=0x3 with flag=1 -> irq=1; CONTROL=0x1 -> irq=0 while new_sample=1; readdata of addr1 = 0x1 one clk after address applied.
